// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin arbiter for a single-port 1024x16 RAM with whole-RAM clear
module ram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic        we_a,
  input  logic [9:0]  addr_a,
  input  logic [15:0] wdata_a,
  output logic        ack_a,
  output logic [15:0] rdata_a,
  input  logic        req_b,
  input  logic        we_b,
  input  logic [9:0]  addr_b,
  input  logic [15:0] wdata_b,
  output logic        ack_b,
  output logic [15:0] rdata_b,
  input  logic        clear,
  output logic        clear_done,
  output logic        busy,
  output logic [9:0]  ram_address,
  output logic [15:0] ram_data_in,
  output logic        ram_rw,
  output logic        ram_reset,
  input  logic [15:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA, CLEAR} state_t;

  state_t state, state_next;
  logic   last_grant;  // 0 = a, 1 = b
  logic   owner;       // 0 = a, 1 = b
  logic   grant;
  logic   grant_sel;
  logic   elig_a;
  logic   elig_b;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_sel  = 1'b0;
    // A requester being acked this cycle is still holding req; mask it.
    elig_a     = req_a & ~ack_a;
    elig_b     = req_b & ~ack_b;
    case (state)
      IDLE: begin
        if (clear) begin
          state_next = CLEAR;
        end else if (elig_a || elig_b) begin
          state_next = ACCESS;
          grant      = 1'b1;
          grant_sel  = (elig_a && elig_b) ? ~last_grant : elig_b;
        end
      end
      ACCESS:  state_next = ram_rw ? RDATA : IDLE;
      RDATA:   state_next = IDLE;
      CLEAR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      rdata_a     <= 16'h0000;
      rdata_b     <= 16'h0000;
      ram_address <= 10'h000;
      ram_data_in <= 16'h0000;
      ram_rw      <= 1'b1;
      clear_done  <= 1'b0;
    end else begin
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            ram_address <= grant_sel ? addr_b : addr_a;
            ram_data_in <= grant_sel ? wdata_b : wdata_a;
            ram_rw      <= grant_sel ? ~we_b : ~we_a;
            owner       <= grant_sel;
            last_grant  <= grant_sel;
          end
        end
        ACCESS: begin
          if (!ram_rw) begin
            if (owner) ack_b <= 1'b1;
            else       ack_a <= 1'b1;
            ram_rw <= 1'b1;
          end
        end
        RDATA: begin
          if (owner) begin
            ack_b   <= 1'b1;
            rdata_b <= ram_data_out;
          end else begin
            ack_a   <= 1'b1;
            rdata_a <= ram_data_out;
          end
        end
        CLEAR:   clear_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign ram_reset = reset | (state == CLEAR);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter with a behavioural 1024x16 RAM
module tb_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        req_a, we_a, req_b, we_b;
  logic [9:0]  addr_a, addr_b;
  logic [15:0] wdata_a, wdata_b;
  logic        ack_a, ack_b;
  logic [15:0] rdata_a, rdata_b;
  logic        clear, clear_done, busy;
  logic [9:0]  ram_address;
  logic [15:0] ram_data_in;
  logic        ram_rw, ram_reset;
  logic [15:0] ram_data_out;

  logic [15:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  ram_arbiter dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .ack_b(ack_b), .rdata_b(rdata_b),
    .clear(clear), .clear_done(clear_done), .busy(busy),
    .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_rw(ram_rw),
    .ram_reset(ram_reset), .ram_data_out(ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: registered read, one-cycle clear while ram_reset is high.
  always @(posedge clk) begin
    if (ram_reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
    end else if (!ram_rw) begin
      mem[ram_address] <= ram_data_in;
    end else begin
      ram_data_out <= mem[ram_address];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit is_b, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (((is_b ? ack_b : ack_a) == 1'b0) && cyc < 20);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
    clear = 0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({ack_a, ack_b} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b expected 00", {ack_a, ack_b}); end
    checks++; if (ram_rw !== 1'b1) begin errors++; $display("FAIL reset_ram_rw: got %b expected 1", ram_rw); end
    checks++; if (ram_address !== 10'h000) begin errors++; $display("FAIL reset_addr: got %h expected 000", ram_address); end
    checks++; if (ram_data_in !== 16'h0000) begin errors++; $display("FAIL reset_din: got %h expected 0000", ram_data_in); end
    checks++; if ({rdata_a, rdata_b} !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", {rdata_a, rdata_b}); end
    checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_clear_done: got %b expected 0", clear_done); end
    checks++; if (ram_reset !== 1'b1) begin errors++; $display("FAIL reset_ram_reset: got %b expected 1", ram_reset); end
    reset = 1'b0;
    #1;
    checks++; if (ram_reset !== 1'b0) begin errors++; $display("FAIL release_ram_reset: got %b expected 0", ram_reset); end
  endtask

  task automatic test_tie();
    logic exp_a, exp_b, exp_rw;
    reset = 1'b1;
    req_a = 1; we_a = 1; addr_a = 10'h010; wdata_a = 16'hAAAA;
    req_b = 1; we_b = 1; addr_b = 10'h020; wdata_b = 16'hBBBB;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_a  = (k == 2) || (k == 6);
      exp_b  = (k == 4) || (k == 8);
      exp_rw = (k % 2 == 0);
      checks++; if ({ack_a, ack_b} !== {exp_a, exp_b}) begin errors++; $display("FAIL tie_acks cycle %0d: got %b expected %b", k, {ack_a, ack_b}, {exp_a, exp_b}); end
      checks++; if (ram_rw !== exp_rw) begin errors++; $display("FAIL tie_ram_rw cycle %0d: got %b expected %b", k, ram_rw, exp_rw); end
    end
    req_a = 0; req_b = 0;
    tick();
    checks++; if (mem[10'h010] !== 16'hAAAA) begin errors++; $display("FAIL tie_mem_a: got %h expected AAAA", mem[10'h010]); end
    checks++; if (mem[10'h020] !== 16'hBBBB) begin errors++; $display("FAIL tie_mem_b: got %h expected BBBB", mem[10'h020]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tie_idle: got %b expected 0", busy); end
  endtask

  task automatic test_write_read();
    int cyc;
    req_a = 1; we_a = 1; addr_a = 10'h005; wdata_a = 16'hBEEF;
    wait_ack(1'b0, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", cyc); end
    req_a = 0;
    tick();
    checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse: got %b expected 0", ack_a); end
    req_a = 1; we_a = 0;
    wait_ack(1'b0, cyc);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", cyc); end
    checks++; if (rdata_a !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h expected BEEF", rdata_a); end
    req_a = 0;
    tick();
    checks++; if (rdata_a !== 16'hBEEF) begin errors++; $display("FAIL rd_data_hold: got %h expected BEEF", rdata_a); end
  endtask

  task automatic test_clear();
    int cyc;
    req_a = 1; we_a = 1; addr_a = 10'h3FF; wdata_a = 16'h1234;
    wait_ack(1'b0, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL clr_wr_latency: got %0d expected 2", cyc); end
    req_a = 0;
    tick();
    checks++; if (mem[10'h3FF] !== 16'h1234) begin errors++; $display("FAIL clr_pre_mem: got %h expected 1234", mem[10'h3FF]); end
    clear = 1;
    tick();
    checks++; if ({busy, ram_reset, clear_done} !== 3'b110) begin errors++; $display("FAIL clr_state: got %b expected 110", {busy, ram_reset, clear_done}); end
    clear = 0;
    tick();
    checks++; if ({busy, clear_done} !== 2'b01) begin errors++; $display("FAIL clr_done: got %b expected 01", {busy, clear_done}); end
    checks++; if (mem[10'h3FF] !== 16'h0000) begin errors++; $display("FAIL clr_mem: got %h expected 0000", mem[10'h3FF]); end
    tick();
    checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL clr_done_pulse: got %b expected 0", clear_done); end
    req_a = 1; we_a = 0;
    wait_ack(1'b0, cyc);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL clr_rd_latency: got %0d expected 3", cyc); end
    checks++; if (rdata_a !== 16'h0000) begin errors++; $display("FAIL clr_rd_data: got %h expected 0000", rdata_a); end
    req_a = 0;
    tick();
  endtask

  task automatic test_clear_during_read();
    int cyc;
    req_b = 1; we_b = 1; addr_b = 10'h00A; wdata_b = 16'h5A5A;
    wait_ack(1'b1, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL cdr_wr_latency: got %0d expected 2", cyc); end
    req_b = 0;
    tick();
    req_b = 1; we_b = 0;
    tick();
    checks++; if ({busy, ram_rw, ram_address} !== {2'b11, 10'h00A}) begin errors++; $display("FAIL cdr_access: got %h expected %h", {busy, ram_rw, ram_address}, {2'b11, 10'h00A}); end
    clear = 1;
    tick();
    checks++; if ({busy, ram_reset, ack_b} !== 3'b100) begin errors++; $display("FAIL cdr_rdata: got %b expected 100", {busy, ram_reset, ack_b}); end
    tick();
    checks++; if (ack_b !== 1'b1) begin errors++; $display("FAIL cdr_ack: got %b expected 1", ack_b); end
    checks++; if (rdata_b !== 16'h5A5A) begin errors++; $display("FAIL cdr_rdata_val: got %h expected 5A5A", rdata_b); end
    req_b = 0;
    tick();
    checks++; if ({ram_reset, clear_done, ack_b} !== 3'b100) begin errors++; $display("FAIL cdr_clear: got %b expected 100", {ram_reset, clear_done, ack_b}); end
    clear = 0;
    tick();
    checks++; if (clear_done !== 1'b1) begin errors++; $display("FAIL cdr_clear_done: got %b expected 1", clear_done); end
    checks++; if (mem[10'h00A] !== 16'h0000) begin errors++; $display("FAIL cdr_mem: got %h expected 0000", mem[10'h00A]); end
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    req_a = 1; we_a = 1; addr_a = 10'h077; wdata_a = 16'hCAFE;
    wait_ack(1'b0, cyc);
    req_a = 0;
    tick();
    req_a = 1; we_a = 0;
    wait_ack(1'b0, cyc);
    checks++; if (rdata_a !== 16'hCAFE) begin errors++; $display("FAIL rm_first_read: got %h expected CAFE", rdata_a); end
    req_a = 0;
    tick();
    req_a = 1;
    tick();
    tick();
    checks++; if ({busy, ack_a} !== 2'b10) begin errors++; $display("FAIL rm_in_rdata: got %b expected 10", {busy, ack_a}); end
    reset = 1; req_a = 0;
    #1;
    checks++; if (ram_reset !== 1'b1) begin errors++; $display("FAIL rm_ram_reset: got %b expected 1", ram_reset); end
    tick();
    checks++; if ({busy, ack_a, ack_b, ram_rw, clear_done} !== 5'b00010) begin errors++; $display("FAIL rm_ctrl: got %b expected 00010", {busy, ack_a, ack_b, ram_rw, clear_done}); end
    checks++; if ({ram_address, ram_data_in, rdata_a} !== 42'h0) begin errors++; $display("FAIL rm_data: got %h expected 0", {ram_address, ram_data_in, rdata_a}); end
    checks++; if (mem[10'h077] !== 16'h0000) begin errors++; $display("FAIL rm_mem: got %h expected 0000", mem[10'h077]); end
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if ({ack_a, ack_b, clear_done, busy} !== 4'b0000) begin errors++; $display("FAIL rm_no_ack cycle %0d: got %b expected 0000", k, {ack_a, ack_b, clear_done, busy}); end
    end
  endtask

  task automatic test_back_to_back();
    req_a = 1; we_a = 1; addr_a = 10'h100; wdata_a = 16'h1111;
    tick();
    req_b = 1; we_b = 1; addr_b = 10'h101; wdata_b = 16'h2222;
    checks++; if ({busy, ram_address} !== {1'b1, 10'h100}) begin errors++; $display("FAIL b2b_a_access: got %h expected %h", {busy, ram_address}, {1'b1, 10'h100}); end
    tick();
    checks++; if ({ack_a, ack_b, busy} !== 3'b100) begin errors++; $display("FAIL b2b_ack_a: got %b expected 100", {ack_a, ack_b, busy}); end
    req_a = 0;
    tick();
    checks++; if ({busy, ram_rw, ram_address} !== {2'b10, 10'h101}) begin errors++; $display("FAIL b2b_b_grant: got %h expected %h", {busy, ram_rw, ram_address}, {2'b10, 10'h101}); end
    tick();
    checks++; if ({ack_a, ack_b, busy} !== 3'b010) begin errors++; $display("FAIL b2b_ack_b: got %b expected 010", {ack_a, ack_b, busy}); end
    tick();
    checks++; if ({ack_b, busy} !== 2'b00) begin errors++; $display("FAIL b2b_no_regrant: got %b expected 00", {ack_b, busy}); end
    req_b = 0;
    tick();
    checks++; if (mem[10'h101] !== 16'h2222) begin errors++; $display("FAIL b2b_mem_b: got %h expected 2222", mem[10'h101]); end
    checks++; if (mem[10'h100] !== 16'h1111) begin errors++; $display("FAIL b2b_mem_a: got %h expected 1111", mem[10'h100]); end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_write_read();
    test_clear();
    test_clear_during_read();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
